score_digit_controller: RTL and testbench

Sequential score engine feeding the 7-digit score overlay. Accepts graded hit events from the note lanes, arbitrates simultaneous hits round-robin, adds their point values into a 7-digit BCD accumulator with a digit-serial adder, and publishes the digits d6..d0 only on frame boundaries so the displayed score never changes mid-frame. Sits between the lane hit judges and the VGA score overlay.

---
 rtl/score_digit_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_score_digit_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_digit_controller.sv
// Score engine for the 7-digit overlay.
// Lane hits are held as pending requests and granted round-robin. Each grant
// adds a hundreds-digit operand into a BCD accumulator, one digit per cycle.
// The displayed digits only follow the accumulator on frame_start.

// Pending slot for one lane: one outstanding graded hit.
module score_lane_pending (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       hit,
  input  logic [1:0] grade_in,
  input  logic       grant,
  output logic       pending,
  output logic [1:0] grade,
  output logic       drop
);
  logic take;

  // Misses (grade 0) are ignored. A hit that arrives on a clear cycle is
  // discarded without being reported as a drop.
  assign take = hit && (grade_in != 2'd0) && !clear;
  // The slot is full and is not being emptied by a grant this cycle.
  assign drop = take && pending && !grant;

  // Capture a new hit when the slot is free or is being granted; free on grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
      grade   <= 2'd0;
    end else if (clear) begin
      pending <= 1'b0;
      grade   <= 2'd0;
    end else if (take && (!pending || grant)) begin
      pending <= 1'b1;
      grade   <= grade_in;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end
endmodule

module score_digit_controller #(
  parameter int LANES       = 4,
  parameter int PTS_GOOD    = 1,
  parameter int PTS_GREAT   = 2,
  parameter int PTS_PERFECT = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [LANES-1:0]     hit_valid,
  input  logic [2*LANES-1:0]   hit_grade,
  input  logic                 score_clear,
  input  logic                 frame_start,
  output logic [3:0]           d6,
  output logic [3:0]           d5,
  output logic [3:0]           d4,
  output logic [3:0]           d3,
  output logic [3:0]           d2,
  output logic [3:0]           d1,
  output logic [3:0]           d0,
  output logic                 busy,
  output logic                 hit_drop,
  output logic                 saturated
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t                  state;
  logic [LANES-1:0]        pending;
  logic [LANES-1:0][1:0]   pgrade;
  logic [LANES-1:0]        grant;
  logic [LANES-1:0]        drop;
  logic [LW-1:0]           last_grant;
  logic [LW-1:0]           gnt_idx;
  logic                    gnt_any;
  logic [2:0]              idx;
  logic                    carry;
  logic [3:0]              op_hund;
  logic [6:0][3:0]         acc;
  logic [6:0][3:0]         shadow;
  logic [6:0][3:0]         disp;
  logic [3:0]              op_digit;
  logic [4:0]              dsum;
  logic                    dcarry;
  logic [3:0]              sum_digit;

  // Hundreds-digit value for a grade.
  function automatic logic [3:0] pts(input logic [1:0] g);
    case (g)
      2'd1:    pts = 4'(PTS_GOOD);
      2'd2:    pts = 4'(PTS_GREAT);
      2'd3:    pts = 4'(PTS_PERFECT);
      default: pts = 4'd0;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      score_lane_pending u_lane (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (score_clear),
        .hit      (hit_valid[gi]),
        .grade_in (hit_grade[2*gi +: 2]),
        .grant    (grant[gi]),
        .pending  (pending[gi]),
        .grade    (pgrade[gi]),
        .drop     (drop[gi])
      );
    end
  endgenerate

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      j = (int'(last_grant) + 1 + k) % LANES;
      if (!gnt_any && pending[j]) begin
        gnt_any = 1'b1;
        gnt_idx = LW'(j);
      end
    end
  end

  // A grant only happens from IDLE and never on a clear cycle.
  always_comb begin
    grant = '0;
    if (state == IDLE && gnt_any && !score_clear) grant[gnt_idx] = 1'b1;
  end

  // One BCD digit of the serial adder. Only the hundreds digit of the operand
  // is ever non-zero.
  assign op_digit  = (idx == 3'd2) ? op_hund : 4'd0;
  assign dsum      = {1'b0, acc[idx]} + {1'b0, op_digit} + {4'd0, carry};
  assign dcarry    = (dsum > 5'd9);
  assign sum_digit = dcarry ? 4'(dsum - 5'd10) : dsum[3:0];

  // Grant / digit-serial add / commit sequencer. The committed accumulator
  // only changes in COMMIT, so an aborted add leaves no partial result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= 3'd0;
      carry      <= 1'b0;
      op_hund    <= 4'd0;
      shadow     <= '0;
      acc        <= '0;
      saturated  <= 1'b0;
      busy       <= 1'b0;
      last_grant <= LW'(LANES - 1);
    end else if (score_clear) begin
      state      <= IDLE;
      idx        <= 3'd0;
      carry      <= 1'b0;
      op_hund    <= 4'd0;
      shadow     <= '0;
      acc        <= '0;
      saturated  <= 1'b0;
      busy       <= 1'b0;
      last_grant <= LW'(LANES - 1);
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            last_grant <= gnt_idx;
            op_hund    <= pts(pgrade[gnt_idx]);
            idx        <= 3'd0;
            carry      <= 1'b0;
            busy       <= 1'b1;
            state      <= ADD;
          end
        end
        ADD: begin
          shadow[idx] <= sum_digit;
          carry       <= dcarry;
          if (idx == 3'd6) state <= COMMIT;
          else             idx   <= idx + 3'd1;
        end
        COMMIT: begin
          // A carry out of the top digit clamps the score at 9999999.
          if (carry) begin
            acc       <= {7{4'd9}};
            saturated <= 1'b1;
          end else begin
            acc <= shadow;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display latch: follows the committed score only at frame start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          disp <= '0;
    else if (score_clear) disp <= '0;
    else if (frame_start) disp <= acc;
  end

  // A lost hit is reported for exactly one cycle, the cycle after the hit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hit_drop <= 1'b0;
    else         hit_drop <= |drop;
  end

  assign d6 = disp[6];
  assign d5 = disp[5];
  assign d4 = disp[4];
  assign d3 = disp[3];
  assign d2 = disp[2];
  assign d1 = disp[1];
  assign d0 = disp[0];
endmodule

// File: tb/tb_score_digit_controller.sv
// Directed bench for score_digit_controller: a table of single-burst vectors
// plus hand-written sequences for timing, arbitration, drops, carry,
// saturation, clear and asynchronous reset.
module tb_score_digit_controller;
  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] hit_valid;
  logic [7:0] hit_grade;
  logic       score_clear;
  logic       frame_start;
  logic [3:0] d6, d5, d4, d3, d2, d1, d0;
  logic       busy, hit_drop, saturated;
  logic [27:0] disp;

  int checks = 0;
  int errors = 0;
  int nb;

  typedef struct {
    logic        clr;
    logic [3:0]  v;
    logic [7:0]  g;
    logic [27:0] exp;
  } vec_t;
  vec_t tbl[8];

  score_digit_controller #(
    .LANES(4), .PTS_GOOD(1), .PTS_GREAT(2), .PTS_PERFECT(3)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .hit_valid   (hit_valid),
    .hit_grade   (hit_grade),
    .score_clear (score_clear),
    .frame_start (frame_start),
    .d6 (d6), .d5 (d5), .d4 (d4), .d3 (d3), .d2 (d2), .d1 (d1), .d0 (d0),
    .busy        (busy),
    .hit_drop    (hit_drop),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;
  assign disp = {d6, d5, d4, d3, d2, d1, d0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a hit burst for exactly one rising edge.
  task automatic hit(input logic [3:0] v, input logic [7:0] g);
    hit_valid = v;
    hit_grade = g;
    cyc(1);
    hit_valid = '0;
    hit_grade = '0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic clr();
    score_clear = 1'b1;
    cyc(1);
    score_clear = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; hit_valid = '0; hit_grade = '0;
    score_clear = 1'b0; frame_start = 1'b0;

    tbl[0] = '{1'b1, 4'b0001, 8'h03, 28'h0000300};
    tbl[1] = '{1'b0, 4'b0100, 8'h20, 28'h0000500};
    tbl[2] = '{1'b0, 4'b1111, 8'h00, 28'h0000500};
    tbl[3] = '{1'b0, 4'b1111, 8'hFF, 28'h0001700};
    tbl[4] = '{1'b0, 4'b1010, 8'h84, 28'h0002000};
    tbl[5] = '{1'b1, 4'b0010, 8'h04, 28'h0000100};
    tbl[6] = '{1'b0, 4'b1001, 8'h42, 28'h0000400};
    tbl[7] = '{1'b0, 4'b0001, 8'hFC, 28'h0000400};

    // Reset state
    cyc(3);
    check("rst_disp", disp, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", hit_drop, 0);
    check("rst_sat", saturated, 0);
    resetn = 1'b1;
    cyc(1);

    // Single perfect hit on lane 0: 8 busy cycles, display waits for frame
    hit(4'b0001, 8'h03);
    check("busy_before_grant", busy, 0);
    nb = 0;
    repeat (10) begin cyc(1); if (busy) nb++; end
    check("busy_cycles", nb, 8);
    check("disp_hold_until_frame", disp, 0);
    frame();
    check("single_perfect", disp, 28'h0000300);

    // Lanes 0 good, 1 great, 3 perfect: grants 0,1,3; frames on commit edges
    clr();
    hit(4'b1011, 8'hC9);
    cyc(8);
    frame();
    check("frame_on_commit_old", disp, 0);
    frame();
    check("grant_lane0_first", disp, 28'h0000100);
    cyc(7);
    frame();
    check("frame_on_commit2_old", disp, 28'h0000100);
    frame();
    check("grant_lane1_second", disp, 28'h0000300);
    cyc(8);
    frame();
    check("burst_total", disp, 28'h0000600);

    // Pointer at lane 3 wraps to lane 0 first
    hit(4'b0011, 8'h0D);
    cyc(9);
    frame();
    check("wrap_lane0_first", disp, 28'h0000700);
    cyc(9);
    frame();
    check("wrap_total", disp, 28'h0001000);

    // Second lane-2 hit while its slot is full is dropped
    clr();
    hit(4'b0001, 8'h02);
    cyc(1);
    hit(4'b0100, 8'h10);
    check("no_drop_first", hit_drop, 0);
    hit(4'b0100, 8'h30);
    check("drop_pulse", hit_drop, 1);
    cyc(1);
    check("drop_one_cycle", hit_drop, 0);
    cyc(20);
    frame();
    check("drop_score", disp, 28'h0000300);

    // Table-driven bursts
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) clr();
      hit(tbl[i].v, tbl[i].g);
      cyc(40);
      frame();
      check($sformatf("tbl_%0d", i), disp, tbl[i].exp);
    end

    // Carry chain: 33 perfect hits then one good hit
    clr();
    repeat (33) begin hit(4'b0001, 8'h03); cyc(9); end
    cyc(2);
    frame();
    check("preload_9900", disp, 28'h0009900);
    hit(4'b0001, 8'h01);
    cyc(10);
    frame();
    check("carry_10000", disp, 28'h0010000);

    // Saturation from a preloaded accumulator
    check("sat_clear_before", saturated, 0);
    force dut.acc = 28'h9999800;
    cyc(1);
    release dut.acc;
    frame();
    check("preload_9999800", disp, 28'h9999800);
    hit(4'b0001, 8'h03);
    cyc(10);
    frame();
    check("saturate_value", disp, 28'h9999999);
    check("saturate_flag", saturated, 1);
    hit(4'b0001, 8'h01);
    cyc(10);
    frame();
    check("saturate_hold", disp, 28'h9999999);
    check("saturate_sticky", saturated, 1);

    // score_clear mid-ADD with lane 1 still pending
    hit(4'b0011, 8'h0F);
    cyc(3);
    clr();
    check("clear_busy", busy, 0);
    check("clear_disp", disp, 0);
    check("clear_sat", saturated, 0);
    nb = 0;
    repeat (20) begin cyc(1); if (busy) nb++; end
    check("clear_pending_gone", nb, 0);
    frame();
    check("clear_no_commit", disp, 0);

    // Asynchronous reset mid-ADD
    hit(4'b0001, 8'h03);
    cyc(10);
    frame();
    check("pre_reset_score", disp, 28'h0000300);
    hit(4'b0001, 8'h03);
    cyc(3);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_disp", disp, 0);
    cyc(1);
    resetn = 1'b1;
    cyc(12);
    check("post_rst_idle", busy, 0);
    frame();
    check("post_rst_no_commit", disp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
